// File: rtl/iter_shifter_pkg.sv
// Shared shift-op and FSM encodings for the iterative shifter and the ALU.
package iter_shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_ROR = 2'b01,
    SH_SRL = 2'b10,
    SH_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } fsm_state_e;

  // Width needed to hold a per-step amount of 0..step inclusive.
  function automatic int unsigned step_k_width(input int unsigned step);
    return $clog2(step) + 1;
  endfunction

endpackage

// File: rtl/iter_shifter_shift_stage.sv
// One combinational shift step of k (0..STEP) bit positions for any shift op.
module shift_stage
  import iter_shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP       = 8
) (
  input  logic [DATA_WIDTH-1:0]          data,
  input  shift_op_e                      op,
  input  logic [step_k_width(STEP)-1:0]  k,
  output logic [DATA_WIDTH-1:0]          shifted
);

  // Rotate is taken from the low half of a doubled operand shifted right.
  always_comb begin
    shifted = data;
    case (op)
      SH_SLL:  shifted = data << k;
      SH_ROR:  shifted = DATA_WIDTH'({data, data} >> k);
      SH_SRL:  shifted = data >> k;
      SH_SRA:  shifted = DATA_WIDTH'($signed(data) >>> k);
      default: shifted = data;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts up to STEP positions per cycle, valid/ready on both sides.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [1:0]            Shiftop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  busy
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
  localparam int unsigned K_W     = step_k_width(STEP);

  fsm_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  shift_op_e               op_q, op_d;
  logic [SHAMT_W-1:0]      rem_q, rem_d;
  logic [K_W-1:0]          step_k;
  logic [DATA_WIDTH-1:0]   stage_data;
  logic [SHAMT_W-1:0]      req_amt;
  logic [DATA_WIDTH-SHAMT_W-1:0] b_unused;

  // Amount is taken modulo DATA_WIDTH; the upper bits of B are dropped.
  assign req_amt  = B[SHAMT_W-1:0];
  assign b_unused = B[DATA_WIDTH-1:SHAMT_W];

  always_comb begin
    if (32'(rem_q) > STEP) step_k = K_W'(STEP);
    else                   step_k = K_W'(rem_q);
  end

  shift_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP)
  ) u_stage (
    .data    (data_q),
    .op      (op_q),
    .k       (step_k),
    .shifted (stage_data)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = A;
          op_d    = shift_op_e'(Shiftop);
          rem_d   = req_amt;
          state_d = (req_amt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        data_d = stage_data;
        rem_d  = rem_q - SHAMT_W'(step_k);
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      op_q      <= SH_SLL;
      rem_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  assign Result = data_q;

endmodule
